// File: rtl/can_pkg.sv
// Shared CAN CRC-15 definitions: sequencer state encoding, polynomial, seed
// and the single-bit LFSR step used by can_crc15_lfsr.
package can_pkg;

  localparam int unsigned CRC_W = 15;
  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;
  localparam logic [CRC_W-1:0] CRC_SEED = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DELIM,
    ST_DONE
  } state_e;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc_seq_if.sv
// Pin bundle for can_crc_seq: master drives the frame controls and bit
// strobes, slave is the sequencer side.
interface can_crc_seq_if;
  import can_pkg::*;

  logic             start;
  logic             tx_mode;
  logic [6:0]       num_bits;
  logic             bit_stb;
  logic             rx_bit;
  logic             abort;
  logic             busy;
  logic             crc_phase;
  logic             tx_crc_bit;
  logic [CRC_W-1:0] crc_val;
  logic             crc_err;
  logic             delim_err;
  logic             done;

  modport master (
    output start, tx_mode, num_bits, bit_stb, rx_bit, abort,
    input  busy, crc_phase, tx_crc_bit, crc_val, crc_err, delim_err, done
  );

  modport slave (
    input  start, tx_mode, num_bits, bit_stb, rx_bit, abort,
    output busy, crc_phase, tx_crc_bit, crc_val, crc_err, delim_err, done
  );

endinterface

// File: rtl/can_crc15_lfsr.sv
// CAN CRC-15 LFSR register; clr has priority over shift.
module can_crc15_lfsr
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_SEED;
    end else if (shift) begin
      crc_d = crc_step(crc_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_crc_seq.sv
// CAN CRC field sequencer: accumulates CRC-15 over SOF..data, then sequences
// and checks the 15 CRC bits. Define CAN_CRC_DELIM_CHECK_EN to check the delimiter.
module can_crc_seq
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tx_mode,
  input  logic [6:0]       num_bits,
  input  logic             bit_stb,
  input  logic             rx_bit,
  input  logic             abort,
  output logic             busy,
  output logic             crc_phase,
  output logic             tx_crc_bit,
  output logic [CRC_W-1:0] crc_val,
  output logic             crc_err,
  output logic             delim_err,
  output logic             done
);

  state_e           state_d, state_q;
  logic [6:0]       cnt_d, cnt_q;
  logic [3:0]       idx_d, idx_q;
  logic             tx_mode_d, tx_mode_q;
  logic             busy_d, busy_q;
  logic             crc_phase_d, crc_phase_q;
  logic             crc_err_d, crc_err_q;
  logic             done_d, done_q;
  logic             lfsr_clr, lfsr_shift;
  logic [CRC_W-1:0] crc_w;
  logic             crc_bit;
  logic             mismatch;
`ifdef CAN_CRC_DELIM_CHECK_EN
  logic             delim_err_d, delim_err_q;
`endif

  can_crc15_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lfsr_clr),
    .shift (lfsr_shift),
    .din   (rx_bit),
    .crc   (crc_w)
  );

  assign crc_bit = crc_w[idx_q];
  // TX compares the bus readback against the bit being driven; RX against the expected bit.
  assign mismatch = tx_mode_q ? (rx_bit != tx_crc_bit) : (rx_bit != crc_bit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_mode_d  = tx_mode_q;
    crc_err_d  = crc_err_q;
    lfsr_clr   = 1'b0;
    lfsr_shift = 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
    delim_err_d = delim_err_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            lfsr_clr  = 1'b1;
            crc_err_d = 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
            delim_err_d = 1'b0;
`endif
            tx_mode_d = tx_mode;
            cnt_d     = num_bits;
            idx_d     = 4'd14;
            state_d   = (num_bits == '0) ? ST_CRC : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_stb) begin
            lfsr_shift = 1'b1;
            cnt_d      = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (bit_stb) begin
            if (mismatch) begin
              crc_err_d = 1'b1;
            end
            if (idx_q == '0) begin
`ifdef CAN_CRC_DELIM_CHECK_EN
              state_d = ST_DELIM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              idx_d = idx_q - 4'd1;
            end
          end
        end
`ifdef CAN_CRC_DELIM_CHECK_EN
        ST_DELIM: begin
          if (bit_stb) begin
            if (!rx_bit) begin
              delim_err_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d      = (state_d != ST_IDLE);
    crc_phase_d = (state_d == ST_CRC);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      tx_mode_q   <= 1'b0;
      busy_q      <= 1'b0;
      crc_phase_q <= 1'b0;
      crc_err_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
      delim_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tx_mode_q   <= tx_mode_d;
      busy_q      <= busy_d;
      crc_phase_q <= crc_phase_d;
      crc_err_q   <= crc_err_d;
      done_q      <= done_d;
`ifdef CAN_CRC_DELIM_CHECK_EN
      delim_err_q <= delim_err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign crc_phase  = crc_phase_q;
  assign tx_crc_bit = crc_phase_q & crc_bit;
  assign crc_val    = crc_w;
  assign crc_err    = crc_err_q;
  assign done       = done_q;
`ifdef CAN_CRC_DELIM_CHECK_EN
  assign delim_err  = delim_err_q;
`else
  assign delim_err  = 1'b0;
`endif

endmodule

// File: doc/can_crc_seq.md
CAN_CRC_SEQ -- requirements
Module: can_crc_seq

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle frame-start pulse.
REQ-004 SHALL have port tx_mode, input, 1, 1=transmit CRC, 0=check received CRC; sampled on accepted start.
REQ-005 SHALL have port num_bits, input, 7, count of destuffed bits SOF..end of data field (0-127); sampled on accepted start.
REQ-006 SHALL have port bit_stb, input, 1, one-cycle strobe marking a valid bit-sample point.
REQ-007 SHALL have port rx_bit, input, 1, destuffed bus bit; valid when bit_stb=1.
REQ-008 SHALL have port abort, input, 1, synchronous cancel (error frame or arbitration loss).
REQ-009 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-010 SHALL have port crc_phase, output, 1, high while the 15 CRC bits are sequenced.
REQ-011 SHALL have port tx_crc_bit, output, 1, current CRC bit to drive, MSB first.
REQ-012 SHALL have port crc_val, output, 15, LFSR register contents.
REQ-013 SHALL have port crc_err, output, 1, sticky received-CRC mismatch flag.
REQ-014 SHALL have port delim_err, output, 1, sticky CRC-delimiter form error.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, DATA, CRC, DELIM, DONE.
REQ-017 SHALL, in IDLE on start, clear LFSR to 15'h0000, clear crc_err and delim_err, load the bit counter, then enter DATA, or CRC if num_bits=0.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL, in DATA on each bit_stb, shift rx_bit into the LFSR (CAN polynomial 0x4599: fb=rx_bit^crc[14]; crc=(crc<<1) xor (fb?0x4599:0)); crc_val updates the following cycle.
REQ-020 SHALL enter CRC on the bit_stb that consumes the num_bits-th bit.
REQ-021 SHALL freeze the LFSR in CRC and use a 4-bit index 14..0; tx_crc_bit = crc_val[index], valid the entire bit period; bit_stb decrements the index.
REQ-022 SHALL, in CRC with tx_mode=0, set crc_err on any bit_stb where rx_bit differs from crc_val[index].
REQ-023 SHALL, in CRC with tx_mode=1, also compare rx_bit (bus readback) and set crc_err on mismatch.
REQ-024 SHALL leave CRC after the bit_stb of index 0, going to DELIM or DONE per REQ-031/032.
REQ-025 SHALL hold DONE exactly one cycle with done=1, then return to IDLE; crc_err, delim_err and crc_val hold until the next accepted start.
REQ-026 SHALL, on abort in any state, return to IDLE next cycle without done pulse; abort overrides simultaneous start and bit_stb.
REQ-027 SHALL ignore bit_stb in IDLE and DONE.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state IDLE, crc_val 0, counter and index 0, and busy, crc_phase, tx_crc_bit, crc_err, delim_err, done all 0.
REQ-029 SHALL abandon any in-progress frame on reset with no done pulse.
REQ-030 SHALL leave outputs unaffected by start, abort or bit_stb while rst_n is low.

Configuration
REQ-031 SHALL, with CAN_CRC_DELIM_CHECK_EN defined, enter DELIM after CRC and on the next bit_stb set delim_err if rx_bit=0, then go to DONE.
REQ-032 SHALL, without CAN_CRC_DELIM_CHECK_EN, omit DELIM, go from CRC directly to DONE, and tie delim_err to 0.

Structure
REQ-033 SHALL place the state enum, CRC width (15), polynomial 0x4599 and seed 0 in shared package can_pkg.
REQ-034 SHALL place the LFSR in sub-module can_crc15_lfsr (ports clk, rst_n, clr, shift, din, crc), controlled by can_crc_seq.

Verification
REQ-035 SHALL check RX with num_bits=1, bit "1", followed by 15 bits 0x4599 MSB first -> crc_val=0x4599, crc_err=0, done pulse.
REQ-036 SHALL check RX with num_bits=2, bits "10", then wrong CRC 0x0000 -> crc_err=1 (expected 0x4EAB).
REQ-037 SHALL check TX with num_bits=0 -> immediate CRC phase, tx_crc_bit=0 for all 15 strobes, done after 15th.
REQ-038 SHALL check abort at bit 5 of 20 with simultaneous start -> IDLE next cycle, no done, busy=0.
REQ-039 SHALL check, with CAN_CRC_DELIM_CHECK_EN, that a delimiter bit 0 after a valid CRC gives delim_err=1, crc_err=0.
REQ-040 SHALL check that rst_n low mid-CRC gives all outputs 0 within the same cycle.
